// File: rtl/pid_pkg.sv
// Shared types for the PID scheduler: FSM states,
// coefficient addresses and accumulator width.
package pid_pkg;

  localparam int ACCW = 20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_M0,
    S_M1,
    S_M2,
    S_SAT,
    S_OUT
  } state_t;

  localparam logic [1:0] CFG_K0 = 2'd0;
  localparam logic [1:0] CFG_K1 = 2'd1;
  localparam logic [1:0] CFG_K2 = 2'd2;

endpackage

// File: rtl/pid_mac_unit.sv
// Registered signed multiply-accumulate shared by
// all channels: acc <= (load ? acc_in : acc) + a*b.
module pid_mac_unit
  import pid_pkg::*;
#(
  parameter int EW = 9,
  parameter int KW = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   load,
  input  logic signed [EW-1:0]   a,
  input  logic signed [KW-1:0]   b,
  input  logic signed [ACCW-1:0] acc_in,
  output logic signed [ACCW-1:0] acc
);

  localparam int PW = EW + KW;

  logic signed [PW-1:0]   a_x;
  logic signed [PW-1:0]   b_x;
  logic signed [PW-1:0]   prod;
  logic signed [ACCW-1:0] base;

  assign a_x  = $signed({{KW{a[EW-1]}}, a});
  assign b_x  = $signed({{EW{b[KW-1]}}, b});
  assign prod = a_x * b_x;
  assign base = load ? acc_in : acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (en) begin
      acc <= base + ACCW'(prod);
    end
  end

endmodule

// File: rtl/pid_sched.sv
// Multi-channel incremental PID scheduler on one MAC.
// Optional PID_SAT_STATUS_EN adds out_sat and sat_cnt.
module pid_sched
  import pid_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int EW      = 9,
  parameter int KW      = 8,
  parameter int UW      = 17,
  parameter int UK_MAX  = 15000,
  parameter int K0_INIT = 5,
  parameter int K1_INIT = 1,
  parameter int K2_INIT = 1,
  localparam int CHW    = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CHW-1:0]       in_ch,
  input  logic signed [EW-1:0] in_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CHW-1:0]       out_ch,
  output logic [UW-1:0]        out_uk,
  input  logic                 cfg_we,
  input  logic [1:0]           cfg_addr,
  input  logic signed [KW-1:0] cfg_data,
  input  logic                 clr_valid,
  input  logic [CHW-1:0]       clr_ch,
  output logic                 busy
`ifdef PID_SAT_STATUS_EN
  ,
  output logic                 out_sat,
  output logic [15:0]          sat_cnt
`endif
);

  state_t state, nstate;

  logic [CHW-1:0]       ch;
  logic signed [EW-1:0] err;
  logic signed [KW-1:0] k0, k1, k2;
  logic signed [KW-1:0] s0, s1, s2;

  logic signed [EW-1:0] e1 [NCH];
  logic signed [EW-1:0] e2 [NCH];
  logic [UW-1:0]        up [NCH];

  logic                   accept;
  logic                   clr_go;
  logic                   mac_en;
  logic                   mac_load;
  logic signed [EW-1:0]   mac_a;
  logic signed [KW-1:0]   mac_b;
  logic signed [ACCW-1:0] acc_in;
  logic signed [ACCW-1:0] acc;
  logic                   lo, hi, sat;
  logic [UW-1:0]          uk_sat;

  assign accept = in_valid && in_ready;
  assign clr_go = (state == S_IDLE) && clr_valid;
  assign acc_in = $signed({{(ACCW-UW){1'b0}}, up[ch]});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      S_IDLE: if (accept) nstate = S_M0;
      S_M0:   nstate = S_M1;
      S_M1:   nstate = S_M2;
      S_M2:   nstate = S_SAT;
      S_SAT:  nstate = S_OUT;
      S_OUT:  if (out_ready) nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  // in_ready is gated by rst_n so it reads low while reset is held
  always_comb begin
    in_ready  = rst_n && (state == S_IDLE) && !clr_valid;
    busy      = (state != S_IDLE);
    out_valid = (state == S_OUT);
    mac_en    = 1'b0;
    mac_load  = 1'b0;
    mac_a     = err;
    mac_b     = s0;
    case (state)
      S_M0: begin
        mac_en   = 1'b1;
        mac_load = 1'b1;
      end
      S_M1: begin
        mac_en = 1'b1;
        mac_a  = e1[ch];
        mac_b  = s1;
      end
      S_M2: begin
        mac_en = 1'b1;
        mac_a  = e2[ch];
        mac_b  = s2;
      end
      default: ;
    endcase
  end

  pid_mac_unit #(
    .EW(EW),
    .KW(KW)
  ) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (mac_en),
    .load   (mac_load),
    .a      (mac_a),
    .b      (mac_b),
    .acc_in (acc_in),
    .acc    (acc)
  );

  always_comb begin
    lo  = acc[ACCW-1];
    hi  = !lo && (acc > $signed(ACCW'(UK_MAX)));
    sat = lo || hi;
    if (lo)      uk_sat = '0;
    else if (hi) uk_sat = UW'(UK_MAX);
    else         uk_sat = acc[UW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k0 <= KW'(K0_INIT);
      k1 <= KW'(K1_INIT);
      k2 <= KW'(K2_INIT);
    end else if (cfg_we) begin
      unique case (1'b1)
        cfg_addr == CFG_K0: k0 <= cfg_data;
        cfg_addr == CFG_K1: k1 <= cfg_data;
        cfg_addr == CFG_K2: k2 <= cfg_data;
        default: ;
      endcase
    end
  end

  // coefficients are snapshotted so mid-flight writes hit the next sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch  <= '0;
      err <= '0;
      s0  <= '0;
      s1  <= '0;
      s2  <= '0;
    end else if (accept) begin
      ch  <= in_ch;
      err <= in_err;
      s0  <= k0;
      s1  <= k1;
      s2  <= k2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        e1[i] <= '0;
        e2[i] <= '0;
        up[i] <= '0;
      end
    end else if (clr_go) begin
      e1[clr_ch] <= '0;
      e2[clr_ch] <= '0;
      up[clr_ch] <= '0;
    end else if (state == S_SAT) begin
      up[ch] <= uk_sat;
      e2[ch] <= e1[ch];
      e1[ch] <= err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_ch <= '0;
      out_uk <= '0;
    end else if (state == S_SAT) begin
      out_ch <= ch;
      out_uk <= uk_sat;
    end
  end

`ifdef PID_SAT_STATUS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sat <= 1'b0;
      sat_cnt <= '0;
    end else if (state == S_SAT) begin
      out_sat <= sat;
      if (sat && (sat_cnt != 16'hffff))
        sat_cnt <= sat_cnt + 16'd1;
    end
  end
`else
  logic unused_sat;
  assign unused_sat = sat;
`endif

endmodule

// File: tb/tb_pid_sched.sv
// Self-checking bench for pid_sched: vector table
// plus scoreboard queue, stall, clear and reset cases.
module tb_pid_sched;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_ch;
  logic signed [8:0] in_err;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_ch;
  logic [16:0]       out_uk;
  logic              cfg_we;
  logic [1:0]        cfg_addr;
  logic signed [7:0] cfg_data;
  logic              clr_valid;
  logic [1:0]        clr_ch;
  logic              busy;
`ifdef PID_SAT_STATUS_EN
  logic              out_sat;
  logic [15:0]       sat_cnt;
`endif

  always #5 clk = ~clk;

  pid_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ch     (in_ch),
    .in_err    (in_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_uk    (out_uk),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .clr_valid (clr_valid),
    .clr_ch    (clr_ch),
    .busy      (busy)
`ifdef PID_SAT_STATUS_EN
    ,
    .out_sat   (out_sat),
    .sat_cnt   (sat_cnt)
`endif
  );

  typedef struct {
    logic [1:0] ch;
    int         err;
    bit         cfg_we;
    logic [1:0] cfg_addr;
    int         cfg_data;
    bit         clr;
    int         stall;
    int         exp;
    bit         sat;
  } vec_t;

  typedef struct {
    logic [1:0] ch;
    int         uk;
    bit         sat;
  } exp_t;

  localparam int NV = 16;
  vec_t tv [NV];
  exp_t q [$];
  int   errors = 0;
  int   checks = 0;
  int   nsat   = 0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  task automatic send(input vec_t v);
    int   n;
    int   lat;
    exp_t e;
    @(negedge clk);
    if (v.cfg_we) begin
      cfg_we   = 1'b1;
      cfg_addr = v.cfg_addr;
      cfg_data = v.cfg_data[7:0];
      @(negedge clk);
      cfg_we = 1'b0;
    end
    if (v.clr) begin
      clr_valid = 1'b1;
      clr_ch    = v.ch;
      in_valid  = 1'b1;
      in_ch     = v.ch;
      in_err    = 9'sd99;
      #1;
      chk("clr_in_ready", int'(in_ready), 0);
      @(negedge clk);
      chk("clr_no_accept", int'(busy), 0);
      clr_valid = 1'b0;
      in_valid  = 1'b0;
      @(negedge clk);
    end
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("ready_timeout", n, 0);
    out_ready = (v.stall == 0);
    in_valid  = 1'b1;
    in_ch     = v.ch;
    in_err    = v.err[8:0];
    q.push_back('{v.ch, v.exp, v.sat});
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      in_valid = 1'b0;
      if (out_valid) break;
    end
    chk("latency", lat, 5);
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("sb_empty", 0, 1);
      end else begin
        e = q.pop_front();
        chk("out_ch", int'(out_ch), int'(e.ch));
        chk("out_uk", int'(out_uk), e.uk);
`ifdef PID_SAT_STATUS_EN
        chk("out_sat", int'(out_sat), int'(e.sat));
`endif
        for (int i = 0; i < v.stall; i++) begin
          @(negedge clk);
          chk("stall_valid", int'(out_valid), 1);
          chk("stall_uk", int'(out_uk), e.uk);
          chk("stall_ready", int'(in_ready), 0);
        end
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("back_idle", int'(busy), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    //        ch err  we ad dat clr st exp   sat
    tv[0]  = '{0, 10,  0, 0, 0,   0, 0, 50,    0};
    tv[1]  = '{0, 10,  0, 0, 0,   0, 0, 110,   0};
    tv[2]  = '{0, 10,  0, 0, 0,   0, 0, 180,   0};
    tv[3]  = '{2, -256,0, 0, 0,   0, 0, 0,     1};
    tv[4]  = '{2, 100, 0, 0, 0,   0, 0, 244,   0};
    tv[5]  = '{2, 0,   0, 0, 0,   0, 0, 88,    0};
    tv[6]  = '{0, 10,  0, 0, 0,   1, 0, 50,    0};
    tv[7]  = '{3, 20,  0, 0, 0,   0, 0, 100,   0};
    tv[8]  = '{0, 10,  0, 0, 0,   0, 0, 110,   0};
    tv[9]  = '{3, 20,  0, 0, 0,   0, 3, 220,   0};
    tv[10] = '{1, 255, 1, 0, 127, 0, 0, 15000, 1};
    tv[11] = '{1, 255, 0, 0, 0,   0, 0, 15000, 1};
    tv[12] = '{1, -256,0, 0, 0,   0, 0, 0,     1};
    tv[13] = '{1, 0,   0, 0, 0,   0, 0, 0,     1};
    tv[14] = '{3, 1,   1, 3, -128,0, 0, 387,   0};
    tv[15] = '{3, 0,   1, 2, -3,  0, 0, 328,   0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_ch     = '0;
    in_err    = '0;
    out_ready = 1'b1;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_data  = '0;
    clr_valid = 1'b0;
    clr_ch    = '0;
    #12;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_uk", int'(out_uk), 0);
    chk("rst_out_ch", int'(out_ch), 0);
`ifdef PID_SAT_STATUS_EN
    chk("rst_sat_cnt", int'(sat_cnt), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", int'(in_ready), 1);

    for (int i = 0; i < NV; i++) begin
      send(tv[i]);
      if (tv[i].sat) nsat++;
    end
`ifdef PID_SAT_STATUS_EN
    chk("sat_cnt", int'(sat_cnt), nsat);
`endif

    // reset asserted while the MAC is in M1
    @(negedge clk);
    in_valid = 1'b1;
    in_ch    = 2'd0;
    in_err   = 9'sd10;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ready", int'(in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("no_out_after_rst", int'(seen), 0);
    send('{0, 10, 0, 0, 0, 0, 0, 50, 0});
`ifdef PID_SAT_STATUS_EN
    chk("sat_cnt_post_rst", int'(sat_cnt), 0);
`endif
    chk("sb_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
